pc_fetch: RTL and testbench

PC_FETCH -- requirements
Module: pc_fetch

---
 rtl/pc_fetch_if.sv | 10 +
 rtl/pc_fetch.sv | 191 +++++++++++++++++++
 tb/tb_pc_fetch.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_if.sv
// Instruction-memory request/acknowledge bus between pc_fetch and memory.
interface pc_fetch_if;
   logic        memReq;
   logic [31:0] memAddr;
   logic        memAck;
   logic [31:0] memData;

   modport master (output memReq, output memAddr, input memAck, input memData);
   modport slave  (input memReq, input memAddr, output memAck, output memData);
endinterface

// File: rtl/pc_fetch.sv
// Instruction fetch stage: walks the PC and issues one memory request at a
// time. It presents each fetched word on ifPC/ifInst/ifValid, honours the
// stall and branch-redirect inputs, and discards in-flight data when a
// redirect arrives. Optional macro IF_MISALIGN_TRAP_EN adds the ifMisalign
// output and a HALT state for redirects to non-word-aligned targets.
module pc_fetch (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        brFlag,
   input  logic [31:0] brTarget,
   pc_fetch_if.master  mem,
   output logic [31:0] ifPC,
   output logic [31:0] ifInst,
   output logic        ifValid
`ifdef IF_MISALIGN_TRAP_EN
   ,
   output logic        ifMisalign
`endif
);

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      HOLD,
      KILL
`ifdef IF_MISALIGN_TRAP_EN
      ,
      HALT
`endif
   } state_t;

   state_t      state, state_n;
   logic [31:0] pc, pc_n;
   logic [31:0] tgt, tgt_n;
   logic        req_q, req_n;
   logic [31:0] addr_q, addr_n;
   logic [31:0] pco_n, inst_n;
   logic        vld_n;
   logic        redir;
   logic [31:0] raddr;
`ifdef IF_MISALIGN_TRAP_EN
   logic        mis_n;
`endif

   assign mem.memReq  = req_q;
   assign mem.memAddr = addr_q;

   // Next-state and registered-output decode; every redirect source funnels
   // through one common block at the end so all states treat targets alike.
   always_comb begin
      state_n = state;
      pc_n    = pc;
      tgt_n   = tgt;
      req_n   = req_q;
      addr_n  = addr_q;
      pco_n   = ifPC;
      inst_n  = ifInst;
      vld_n   = ifValid;
      redir   = 1'b0;
      raddr   = '0;
`ifdef IF_MISALIGN_TRAP_EN
      mis_n   = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (brFlag) begin
               redir = 1'b1;
               raddr = brTarget;
            end else begin
               state_n = REQ;
               req_n   = 1'b1;
               addr_n  = pc;
            end
         end
         REQ: begin
            if (brFlag) begin
               if (mem.memAck) begin
                  redir = 1'b1;
                  raddr = brTarget;
               end else begin
                  // Access still in flight: its data must be swallowed first.
                  tgt_n   = brTarget;
                  state_n = KILL;
                  vld_n   = 1'b0;
                  inst_n  = '0;
               end
            end else if (mem.memAck) begin
               pco_n  = pc;
               inst_n = mem.memData;
               vld_n  = 1'b1;
               pc_n   = pc + 32'd4;
               // Stall seen in the ack cycle parks the word just captured.
               if (stall) begin
                  state_n = HOLD;
                  req_n   = 1'b0;
               end else begin
                  addr_n = pc + 32'd4;
               end
            end else begin
               vld_n  = 1'b0;
               inst_n = '0;
            end
         end
         KILL: begin
            vld_n  = 1'b0;
            inst_n = '0;
            if (mem.memAck) begin
               redir = 1'b1;
               raddr = brFlag ? brTarget : tgt;
            end else if (brFlag) begin
               tgt_n = brTarget;
            end
         end
         HOLD: begin
            if (brFlag) begin
               redir = 1'b1;
               raddr = brTarget;
            end else if (!stall) begin
               state_n = REQ;
               req_n   = 1'b1;
               addr_n  = pc;
            end
         end
`ifdef IF_MISALIGN_TRAP_EN
         HALT: begin
            vld_n = 1'b0;
            if (brFlag) begin
               redir = 1'b1;
               raddr = brTarget;
            end
         end
`endif
         default: begin
            state_n = IDLE;
            req_n   = 1'b0;
         end
      endcase

      if (redir) begin
`ifdef IF_MISALIGN_TRAP_EN
         if (raddr[1:0] != 2'b00) begin
            state_n = HALT;
            req_n   = 1'b0;
            pco_n   = raddr;
            inst_n  = '0;
            vld_n   = 1'b1;
            mis_n   = 1'b1;
         end else
`endif
         begin
            pc_n    = raddr & 32'hFFFF_FFFC;
            addr_n  = raddr & 32'hFFFF_FFFC;
            state_n = REQ;
            req_n   = 1'b1;
            vld_n   = 1'b0;
            inst_n  = '0;
         end
      end
   end

   // State, PC, memory-request and IF-output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         pc      <= '0;
         tgt     <= '0;
         req_q   <= 1'b0;
         addr_q  <= '0;
         ifPC    <= '0;
         ifInst  <= '0;
         ifValid <= 1'b0;
`ifdef IF_MISALIGN_TRAP_EN
         ifMisalign <= 1'b0;
`endif
      end else begin
         state   <= state_n;
         pc      <= pc_n;
         tgt     <= tgt_n;
         req_q   <= req_n;
         addr_q  <= addr_n;
         ifPC    <= pco_n;
         ifInst  <= inst_n;
         ifValid <= vld_n;
`ifdef IF_MISALIGN_TRAP_EN
         ifMisalign <= mis_n;
`endif
      end
   end

endmodule

// File: tb/tb_pc_fetch.sv
// Self-checking bench for pc_fetch: a granted-ack memory model feeds the
// DUT; expected deliveries are queued per scenario and compared as each new
// instruction appears on the IF outputs.
module tb_pc_fetch;
   localparam logic [31:0] K = 32'hA5A5_A5A5;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        stall = 1'b0;
   logic        brFlag = 1'b0;
   logic [31:0] brTarget = '0;
   logic [31:0] ifPC;
   logic [31:0] ifInst;
   logic        ifValid;
`ifdef IF_MISALIGN_TRAP_EN
   logic        ifMisalign;
`endif

   pc_fetch_if mem ();

   pc_fetch dut (
      .clk      (clk),
      .rst      (rst),
      .stall    (stall),
      .brFlag   (brFlag),
      .brTarget (brTarget),
      .mem      (mem),
      .ifPC     (ifPC),
      .ifInst   (ifInst),
      .ifValid  (ifValid)
`ifdef IF_MISALIGN_TRAP_EN
      ,
      .ifMisalign (ifMisalign)
`endif
   );

   always #5 clk = ~clk;

   int unsigned nvec = 0;
   int unsigned nerr = 0;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
   } exp_t;
   exp_t        sb[$];
   int unsigned sb_rd = 0;

   // memory model controls (written only by the main process)
   int unsigned granted = 0;
   int unsigned lat = 0;
   logic        rst_ack = 1'b0;
   // memory model state (written only by the model)
   int unsigned acked = 0;
   int unsigned cnt = 0;

   logic        prev_v = 1'b0;
   logic [31:0] prev_pc = '0;

   // memory: acks a request after lat wait cycles while grants remain
   always @(negedge clk) begin
      if (!rst) begin
         mem.memAck  = rst_ack;
         mem.memData = 32'hDEAD_BEEF;
         cnt = 0;
      end else if (mem.memReq && acked < granted) begin
         if (cnt >= lat) begin
            mem.memAck  = 1'b1;
            mem.memData = mem.memAddr ^ K;
            acked++;
            cnt = 0;
         end else begin
            mem.memAck  = 1'b0;
            mem.memData = 32'hDEAD_BEEF;
            cnt++;
         end
      end else begin
         mem.memAck  = 1'b0;
         mem.memData = 32'hDEAD_BEEF;
         cnt = 0;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic push(input logic [31:0] pc, input logic [31:0] inst);
      exp_t e;
      e.pc   = pc;
      e.inst = inst;
      sb.push_back(e);
   endtask

   // one cycle: scoreboard compare at negedge, then return 1 unit later
   task automatic step();
      @(negedge clk);
      if (rst && ifValid && !(prev_v && ifPC == prev_pc)) begin
         if (sb_rd >= sb.size()) begin
            chk("sb_extra", {31'b0, ifValid}, 32'd0);
         end else begin
            chk("sb_pc", ifPC, sb[sb_rd].pc);
            chk("sb_inst", ifInst, sb[sb_rd].inst);
            sb_rd++;
         end
      end
      prev_v  = rst && ifValid;
      prev_pc = ifPC;
      #1;
   endtask

   task automatic wait_deliver(input logic [31:0] pc);
      bit hit = 1'b0;
      for (int i = 0; i < 40 && !hit; i++) begin
         step();
         if (ifValid && ifPC == pc) hit = 1'b1;
      end
      chk("deliver_vld", {31'b0, ifValid}, 32'd1);
      chk("deliver_pc", ifPC, pc);
   endtask

   initial begin
      int unsigned gap;
      bit          done;
      logic [31:0] a;

      // reset state, with memAck asserted during reset
      rst_ack = 1'b1;
      repeat (2) step();
      chk("rst_ifpc", ifPC, 32'd0);
      chk("rst_ifinst", ifInst, 32'd0);
      chk("rst_ifvalid", {31'b0, ifValid}, 32'd0);
      chk("rst_memreq", {31'b0, mem.memReq}, 32'd0);
      chk("rst_memaddr", mem.memAddr, 32'd0);
`ifdef IF_MISALIGN_TRAP_EN
      chk("rst_mis", {31'b0, ifMisalign}, 32'd0);
`endif

      // zero-wait streaming from address 0
      for (int i = 0; i < 4; i++) push(32'(4 * i), 32'(4 * i) ^ K);
      lat = 0;
      granted += 4;
      rst = 1'b1;
      rst_ack = 1'b0;
      chk("idle_memreq", {31'b0, mem.memReq}, 32'd0);
      step();
      chk("first_memreq", {31'b0, mem.memReq}, 32'd1);
      chk("first_memaddr", mem.memAddr, 32'd0);
      chk("first_ifvalid", {31'b0, ifValid}, 32'd0);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("zw_valid", {31'b0, ifValid}, 32'd1);
         chk("zw_pc", ifPC, 32'(4 * i));
         chk("zw_inst", ifInst, 32'(4 * i) ^ K);
      end

      // three-cycle ack latency
      for (int i = 0; i < 3; i++) push(32'(16 + 4 * i), 32'(16 + 4 * i) ^ K);
      lat = 3;
      granted += 3;
      wait_deliver(32'h10);
      for (int r = 1; r < 3; r++) begin
         a = 32'(16 + 4 * r);
         gap = 0;
         done = 1'b0;
         for (int i = 0; i < 10 && !done; i++) begin
            step();
            if (ifValid) begin
               done = 1'b1;
            end else begin
               chk("wait_inst", ifInst, 32'd0);
               chk("wait_addr", mem.memAddr, a);
               chk("wait_req", {31'b0, mem.memReq}, 32'd1);
               gap++;
            end
         end
         chk("wait_gap", gap, 32'd3);
         chk("wait_pc", ifPC, a);
      end
      chk("sb_drain1", sb.size() - sb_rd, 32'd0);

      // reset in the middle of an unacked request (address 0x1C)
      rst_ack = 1'b1;
      rst = 1'b0;
      #1;
      chk("arst_memreq", {31'b0, mem.memReq}, 32'd0);
      chk("arst_memaddr", mem.memAddr, 32'd0);
      chk("arst_ifvalid", {31'b0, ifValid}, 32'd0);
      chk("arst_ifpc", ifPC, 32'd0);
      repeat (2) step();

      // stall for 5 cycles in the ack cycle of address 8
      for (int i = 0; i < 4; i++) push(32'(4 * i), 32'(4 * i) ^ K);
      lat = 0;
      granted += 4;
      rst = 1'b1;
      rst_ack = 1'b0;
      step();
      chk("re_memreq", {31'b0, mem.memReq}, 32'd1);
      chk("re_memaddr", mem.memAddr, 32'd0);
      wait_deliver(32'h4);
      stall = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("hold_pc", ifPC, 32'h8);
         chk("hold_valid", {31'b0, ifValid}, 32'd1);
         chk("hold_memreq", {31'b0, mem.memReq}, 32'd0);
      end
      stall = 1'b0;
      step();
      chk("hold_pc6", ifPC, 32'h8);
      chk("resume_memreq", {31'b0, mem.memReq}, 32'd1);
      chk("resume_addr", mem.memAddr, 32'hC);
      wait_deliver(32'hC);

      // redirect while 0x10 is unacked, ack two cycles later
      push(32'h100, 32'h100 ^ K);
      brFlag = 1'b1;
      brTarget = 32'h100;
      step();
      brFlag = 1'b0;
      chk("kill_addr", mem.memAddr, 32'h10);
      chk("kill_req", {31'b0, mem.memReq}, 32'd1);
      chk("kill_valid", {31'b0, ifValid}, 32'd0);
      granted += 2;
      step();
      chk("kill_addr2", mem.memAddr, 32'h10);
      wait_deliver(32'h100);

      // redirect and stall together while in HOLD
      push(32'h104, 32'h104 ^ K);
      push(32'h200, 32'h200 ^ K);
      stall = 1'b1;
      granted += 1;
      wait_deliver(32'h104);
      chk("hold2_memreq", {31'b0, mem.memReq}, 32'd0);
      brFlag = 1'b1;
      brTarget = 32'h200;
      granted += 1;
      step();
      chk("brhold_valid", {31'b0, ifValid}, 32'd0);
      chk("brhold_addr", mem.memAddr, 32'h200);
      chk("brhold_req", {31'b0, mem.memReq}, 32'd1);
      brFlag = 1'b0;
      stall = 1'b0;
      wait_deliver(32'h200);

      // misaligned redirect target 0x202, then redirect to 0x300
      brFlag = 1'b1;
      brTarget = 32'h202;
`ifdef IF_MISALIGN_TRAP_EN
      push(32'h202, 32'd0);
      granted += 1;
`else
      push(32'h200, 32'h200 ^ K);
      granted += 2;
`endif
      step();
      brFlag = 1'b0;
`ifdef IF_MISALIGN_TRAP_EN
      wait_deliver(32'h202);
      chk("mis_flag", {31'b0, ifMisalign}, 32'd1);
      chk("mis_inst", ifInst, 32'd0);
      step();
      chk("mis_flag_clr", {31'b0, ifMisalign}, 32'd0);
      chk("halt_valid", {31'b0, ifValid}, 32'd0);
      chk("halt_memreq", {31'b0, mem.memReq}, 32'd0);
      step();
      chk("halt_memreq2", {31'b0, mem.memReq}, 32'd0);
      granted += 1;
`else
      wait_deliver(32'h200);
      granted += 2;
`endif
      push(32'h300, 32'h300 ^ K);
      brFlag = 1'b1;
      brTarget = 32'h300;
      step();
      brFlag = 1'b0;
      wait_deliver(32'h300);

      repeat (3) step();
      chk("sb_drain_end", sb.size() - sb_rd, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
